// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receive FIFO default depth and the status
// word layout that the bus interface status register reuses.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int RX_FIFO_DEPTH = 8;
    localparam int RX_FIFO_CNT_W = $clog2(RX_FIFO_DEPTH + 1);

    typedef struct packed {
        logic                     empty;
        logic                     full;
        logic                     overrun;
        logic [RX_FIFO_CNT_W-1:0] count;
    } fifo_status_t;

    function automatic logic is_rising(input logic lvl, input logic lvl_q);
        return lvl & ~lvl_q;
    endfunction

endpackage

// File: rtl/rx_rdy_edge.sv
// Rising-edge detector on a data-ready level. The history register resets to 1 so
// a level held high across reset never produces a pulse.
module rx_rdy_edge
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_lvl,
    output logic o_pulse
);

    logic r_lvl_q;

    // Previous-cycle copy of the level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl_q <= 1'b1;
        end else begin
            r_lvl_q <= i_lvl;
        end
    end

    assign o_pulse = is_rising(i_lvl, r_lvl_q);

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO, first-word-fall-through, with sticky overrun.
// Define RX_FIFO_THRESH_IRQ_EN to add the fill-level interrupt output thresh_irq.
module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
`ifdef RX_FIFO_THRESH_IRQ_EN
    ,
    parameter int THRESH = 4
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_rdy,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overrun,
    input  logic                       clr_overrun
`ifdef RX_FIFO_THRESH_IRQ_EN
    ,
    output logic                       thresh_irq
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overrun;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;

    rx_rdy_edge u_rdy_edge (
        .clk     (clk),
        .reset   (reset),
        .i_lvl   (rx_rdy),
        .o_pulse (w_push)
    );

    assign empty    = (r_count == CNT_ZERO);
    assign full     = (r_count == CNT_FULL);
    assign w_pop    = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted
    assign w_accept = w_push & (~full | w_pop);
    assign w_drop   = w_push & full & ~w_pop;

    // Next occupancy from accepted push and effective pop
    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= CNT_ZERO;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_accept && !reset) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign overrun = r_overrun;

`ifdef RX_FIFO_THRESH_IRQ_EN
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESH);
    logic r_thresh_irq;

    // Registered from the next count so it rises together with count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_thresh_irq <= 1'b0;
        end else begin
            r_thresh_irq <= (w_count_next >= CNT_THRESH);
        end
    end

    assign thresh_irq = r_thresh_irq;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo: stimulus queues expected bytes, a negedge
// monitor compares every popped head byte against the queue.
module tb_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overrun;
    logic       clr_overrun;
`ifdef RX_FIFO_THRESH_IRQ_EN
    logic       thresh_irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    rx_byte_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef RX_FIFO_THRESH_IRQ_EN
        ,
        .thresh_irq  (thresh_irq)
`endif
    );

    // Monitor: every cycle that pops, the head byte must match the scoreboard
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got %02h required none", rd_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data got %02h required %02h", rd_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    // One frame: level high for hold cycles then low for one
    task automatic frame(input logic [7:0] b, input bit accept);
        rx_data = b;
        rx_rdy  = 1'b1;
        if (accept) sb.push_back(b);
        step();
        step();
        rx_rdy = 1'b0;
        step();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) step();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_empty", {7'd0, empty}, 8'd1);
        chk("rst_full", {7'd0, full}, 8'd0);
        chk("rst_count", {4'd0, count}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);

        // Single frame with a long level: exactly one push
        rx_data = 8'hA5; rx_rdy = 1'b1; sb.push_back(8'hA5);
        step();
        chk("single_empty", {7'd0, empty}, 8'd0);
        chk("single_count", {4'd0, count}, 8'd1);
        repeat (19) step();
        chk("single_hold_count", {4'd0, count}, 8'd1);
        rx_rdy = 1'b0;
        step();
        pop_n(1);
        chk("single_pop_empty", {7'd0, empty}, 8'd1);
        chk("single_pop_count", {4'd0, count}, 8'd0);

        // Fill to full, then drop the ninth byte
        for (int i = 1; i <= 8; i++) frame(8'(i), 1'b1);
        chk("fill_full", {7'd0, full}, 8'd1);
        chk("fill_count", {4'd0, count}, 8'd8);
        frame(8'h09, 1'b0);
        chk("drop_overrun", {7'd0, overrun}, 8'd1);
        chk("drop_count", {4'd0, count}, 8'd8);
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("clr_overrun", {7'd0, overrun}, 8'd0);
        // Set and clear together: set wins
        rx_data = 8'h0A; rx_rdy = 1'b1; clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("clr_vs_set", {7'd0, overrun}, 8'd1);
        rx_rdy = 1'b0;
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("clr_alone", {7'd0, overrun}, 8'd0);
        pop_n(8);
        chk("drain_empty", {7'd0, empty}, 8'd1);

        // Wrap with simultaneous push and pop at full
        for (int i = 0; i < 6; i++) frame(8'h11 + 8'(i), 1'b1);
        pop_n(5);
        chk("wrap_count1", {4'd0, count}, 8'd1);
        for (int i = 0; i < 7; i++) frame(8'h17 + 8'(i), 1'b1);
        chk("wrap_full", {7'd0, full}, 8'd1);
        rx_data = 8'h1E; rx_rdy = 1'b1; rd_en = 1'b1; sb.push_back(8'h1E);
        step();
        rd_en = 1'b0;
        chk("simul_count", {4'd0, count}, 8'd8);
        chk("simul_overrun", {7'd0, overrun}, 8'd0);
        step(); rx_rdy = 1'b0; step();
        pop_n(8);
        chk("wrap_drain_empty", {7'd0, empty}, 8'd1);

        // Read while empty is ignored; push with rd_en while empty is accepted
        pop_n(3);
        chk("rd_empty_count", {4'd0, count}, 8'd0);
        chk("rd_empty_overrun", {7'd0, overrun}, 8'd0);
        rx_data = 8'h5C; rx_rdy = 1'b1; rd_en = 1'b1; sb.push_back(8'h5C);
        step();
        rd_en = 1'b0;
        chk("push_rd_empty_count", {4'd0, count}, 8'd1);
        rx_rdy = 1'b0; step();
        pop_n(1);
        chk("push_rd_empty_drain", {4'd0, count}, 8'd0);

        // Reset while rx_rdy held high discards contents and re-captures nothing
        frame(8'h31, 1'b1); frame(8'h32, 1'b1); frame(8'h33, 1'b1);
        chk("pre_reset_count", {4'd0, count}, 8'd3);
        rx_data = 8'h77; rx_rdy = 1'b1; reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        chk("mid_reset_count", {4'd0, count}, 8'd0);
        chk("mid_reset_empty", {7'd0, empty}, 8'd1);
        chk("mid_reset_overrun", {7'd0, overrun}, 8'd0);
        repeat (5) step();
        chk("held_rdy_no_push", {4'd0, count}, 8'd0);
        rx_rdy = 1'b0; step();
        rx_data = 8'h88; rx_rdy = 1'b1; sb.push_back(8'h88);
        step();
        chk("post_reset_push", {4'd0, count}, 8'd1);
        rx_rdy = 1'b0; step();
        pop_n(1);

`ifdef RX_FIFO_THRESH_IRQ_EN
        for (int i = 0; i < 3; i++) frame(8'h41 + 8'(i), 1'b1);
        chk("thr_below", {7'd0, thresh_irq}, 8'd0);
        rx_data = 8'h44; rx_rdy = 1'b1; sb.push_back(8'h44);
        step();
        chk("thr_rise", {7'd0, thresh_irq}, 8'd1);
        rx_rdy = 1'b0; step();
        pop_n(1);
        chk("thr_fall", {7'd0, thresh_irq}, 8'd0);
        pop_n(3);
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
